// File: rtl/lb_timer_pkg.sv
// rtl/lb_timer_pkg.sv - lb_timer register word offsets and CTRL bit positions
package lb_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_COMPARE  = 3'd4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO_CLR = 1;
  localparam int CTRL_IRQ_EN   = 2;

endpackage

// File: rtl/xt_bus_pkg.sv
// rtl/xt_bus_pkg.sv - LB slave command type, write-width encoding and lane merge helper
package xt_bus_pkg;

  localparam int LB_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    LB_BYTE = 2'b00,
    LB_HALF = 2'b01,
    LB_WORD = 2'b10,
    LB_RSVD = 2'b11
  } lb_width_e;

  typedef struct packed {
    logic                     ren;
    logic                     wen;
    logic [LB_ADDR_WIDTH-1:0] addr;
    logic [31:0]              wdata;
    lb_width_e                write_width;
  } lb_slave_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } lb_merge_t;

  // Places right-aligned wdata into the addressed lanes of cur; valid=0 for misaligned or reserved widths.
  function automatic lb_merge_t lb_merge_wdata(input logic [31:0] cur, input logic [31:0] wdata,
                                               input lb_width_e width, input logic [1:0] off);
    lb_merge_t   r;
    logic [31:0] mask;
    logic [31:0] data;
    logic [4:0]  sh;
    sh      = {off, 3'b000};
    mask    = '0;
    data    = '0;
    r.valid = 1'b0;
    case (width)
      LB_BYTE: begin
        r.valid = 1'b1;
        mask    = 32'h0000_00FF << sh;
        data    = {24'b0, wdata[7:0]} << sh;
      end
      LB_HALF: begin
        r.valid = ~off[0];
        mask    = 32'h0000_FFFF << sh;
        data    = {16'b0, wdata[15:0]} << sh;
      end
      LB_WORD: begin
        r.valid = (off == 2'b00);
        mask    = '1;
        data    = wdata;
      end
      default: r.valid = 1'b0;
    endcase
    r.data = (cur & ~mask) | (data & mask);
    return r;
  endfunction

endpackage

// File: rtl/lb_prescaler.sv
// rtl/lb_prescaler.sv - free-running prescaler producing a one-cycle tick every PRESCALE+1 cycles
module lb_prescaler #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 lb_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] prescale,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] cnt_q, cnt_d;

  // A prescale lowered below cnt_q lets the counter wrap through 2^PSC_WIDTH before matching.
  always_comb begin
    tick  = en & (cnt_q == prescale);
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lb_timer.sv
// rtl/lb_timer.sv - LB timer/compare responder with zero-latency reads and level irq
module lb_timer
  import xt_bus_pkg::*;
  import lb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          PSC_WIDTH = 16
) (
  input  logic        lb_clk,
  input  logic        rst,
  input  lb_slave_t   bus,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [2:0]           ctrl_q, ctrl_d;
  logic                 match_q, match_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d;
  logic [31:0]          count_q, count_d;
  logic [31:0]          compare_q, compare_d;

  logic        hit, tick, we, cmp_hit;
  logic [2:0]  word;
  logic [31:0] cur, rd_val;
  lb_merge_t   m;

  assign hit  = (bus.addr[LB_ADDR_WIDTH-1:5] == BASE_ADDR[LB_ADDR_WIDTH-1:5]);
  assign word = bus.addr[4:2];

  lb_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_psc (
    .lb_clk   (lb_clk),
    .rst      (rst),
    .en       (ctrl_q[CTRL_EN]),
    .prescale (psc_q),
    .tick     (tick)
  );

  // STATUS merges against zero so only a written 1 in lane 0 reaches bit 0.
  always_comb begin
    cur    = '0;
    rd_val = '0;
    case (word)
      REG_CTRL:     begin cur = {29'b0, ctrl_q}; rd_val = {29'b0, ctrl_q}; end
      REG_STATUS:   rd_val = {31'b0, match_q};
      REG_PRESCALE: begin cur = 32'(psc_q); rd_val = 32'(psc_q); end
      REG_COUNT:    begin cur = count_q; rd_val = count_q; end
      REG_COMPARE:  begin cur = compare_q; rd_val = compare_q; end
      default:      begin cur = '0; rd_val = '0; end
    endcase
    m     = lb_merge_wdata(cur, bus.wdata, bus.write_width, bus.addr[1:0]);
    rdata = (bus.ren && hit) ? rd_val : 32'h0;
  end

  always_comb begin
    we        = bus.wen & hit & m.valid;
    cmp_hit   = tick & (count_q == compare_q);
    ctrl_d    = ctrl_q;
    psc_d     = psc_q;
    compare_d = compare_q;
    count_d   = count_q;
    match_d   = match_q;
    if (cmp_hit)   count_d = ctrl_q[CTRL_AUTO_CLR] ? 32'h0 : count_q + 32'h1;
    else if (tick) count_d = count_q + 32'h1;
    if (we) begin
      case (word)
        REG_CTRL:     ctrl_d    = m.data[2:0];
        REG_STATUS:   if (m.data[0]) match_d = 1'b0;
        REG_PRESCALE: psc_d     = m.data[PSC_WIDTH-1:0];
        REG_COUNT:    count_d   = m.data;
        REG_COMPARE:  compare_d = m.data;
        default:      ;
      endcase
    end
    // A new match outranks a coincident write-1-to-clear.
    if (cmp_hit) match_d = 1'b1;
  end

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      psc_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign irq = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: doc/lb_timer.md
Name: lb_timer

Overview:
Low-speed bus (LB) responder: a memory-mapped 32-bit timer/compare peripheral on the lb_clk side of the HB-to-LB bridge.
- Decodes lb_slave_t cycles addressed to its window; serves byte/half/word writes and single-cycle reads.
- Drives its lb_data_in slot, which the bridge OR-combines with the other slaves.
- Raises a level interrupt on compare match.

Parameters:
- BASE_ADDR, 0, LB byte address of the 32-byte register window; bits [4:0] must be zero.
- PSC_WIDTH, 16, width of the prescaler register and prescaler counter.

Ports:
- lb_clk  input  1  LB clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- bus  input  lb_slave_t  LB command: ren, wen, addr[LB_ADDR_WIDTH-1:0], wdata[31:0], write_width[1:0].
- rdata  output  32  read data into the bridge's OR-mux; all zero unless this slave is selected for read.
- irq  output  1  level interrupt; equals MATCH & IRQ_EN.

Behaviour:
- Select: hit = addr[LB_ADDR_WIDTH-1:5] == BASE_ADDR[LB_ADDR_WIDTH-1:5]. Word index = addr[4:2]. Byte offset = addr[1:0].
- Register map (word offsets):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO_CLR, bit2 IRQ_EN; other bits read 0.
  - 0x04 STATUS: bit0 MATCH; write 1 to clear.
  - 0x08 PRESCALE, RW, [PSC_WIDTH-1:0].
  - 0x0C COUNT, RW.
  - 0x10 COMPARE, RW.
  - 0x14..0x1C: read 0, writes ignored.
- Reads:
  - rdata is combinational from ren & hit and the register selected by addr; it is valid in the same lb_clk cycle ren is high.
  - The bridge samples rdata on the edge that ends its one-cycle ren pulse. Zero latency is therefore mandatory.
  - rdata = 0 whenever !(ren & hit).
  - Reads have no side effects.
- Writes:
  - A write takes effect on the lb_clk edge where wen & hit.
  - write_width: 00 byte, 01 half, 10 word, 11 reserved (ignored).
  - wdata is right-aligned: byte uses wdata[7:0] placed at lane addr[1:0]; half uses wdata[15:0] at lanes addr[1]*2; word uses wdata[31:0].
  - Misaligned half (addr[0]=1) or word (addr[1:0]!=0): write ignored.
  - Only the addressed lanes change.
- ren and wen are never high together; the bridge issues write then read in separate cycles. If both are seen, the write is performed and rdata still follows the read address.
- Prescaler:
  - psc_cnt counts up while EN=1.
  - When psc_cnt == PRESCALE: tick=1 for one cycle and psc_cnt <= 0.
  - PRESCALE=0 ticks every cycle.
  - EN=0 holds psc_cnt at 0 and tick=0.
- Counter: on tick, if COUNT == COMPARE then MATCH <= 1 and COUNT <= AUTO_CLR ? 0 : COUNT+1. Otherwise COUNT <= COUNT+1, wrapping 0xFFFFFFFF to 0.
- Simultaneous events:
  - A software write to COUNT in a tick cycle wins over increment/clear; MATCH still sets if the old COUNT matched.
  - W1C of MATCH coinciding with a new match: MATCH stays 1 (set wins).
  - A write to PRESCALE takes effect for the next comparison; psc_cnt is not cleared. If psc_cnt > new PRESCALE, it wraps through 2^PSC_WIDTH.
- irq = MATCH & IRQ_EN, combinational from registers, glitch-free.
- Reset (asynchronous, any time including mid-count): all registers, psc_cnt and MATCH go to 0. irq=0; rdata=0 once ren is low.

Decomposition:
- XT_BUS package:
  - write_width encoding enum (BYTE/HALF/WORD).
  - A shared function merging right-aligned wdata into a 32-bit register by width and offset, returning a valid flag for alignment. Later LB slaves reuse it.
- Local package lb_timer_pkg: register word-offset constants and CTRL bit positions.
- One sub-module, lb_prescaler (PSC_WIDTH, lb_clk, rst, en, prescale -> tick).

Test Plan:
- Reset, then read all 8 words at BASE_ADDR -> every read returns 0x00000000; irq=0; rdata=0 when ren is low or the address misses the window.
- Word write 0x12345678 to COMPARE; byte write 0xAB at offset 0x11; half write 0xCDEF at offset 0x12 -> COMPARE reads 0xCDEFAB78. Word write at offset 0x11 -> ignored.
- PRESCALE=2, COMPARE=3, CTRL=0b111 -> COUNT increments every 3 cycles. MATCH and irq rise on the tick seen with COUNT==3, and COUNT becomes 0.
- AUTO_CLR=0, COUNT written 0xFFFFFFFE, PRESCALE=0, EN=1 -> COUNT reads 0xFFFFFFFF, then 0x00000000 (wrap), with no MATCH unless COMPARE equals one of those values.
- MATCH=1; write STATUS=1 in the same cycle as another match -> MATCH stays 1. W1C in a non-match cycle -> MATCH=0 and irq drops the next cycle.
- Assert rst mid-count with COUNT=0x55 -> COUNT, CTRL, MATCH and irq go to 0 immediately (asynchronously). After release, COUNT stays 0 until EN is rewritten.
